// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
//   Shared definitions for the registered bitwise logic unit:
//   operation encoding, op-select width and output-stage state type.
package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    // Output register occupancy: EMPTY <=> out_valid=0, FULL <=> out_valid=1.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/logic_unit_n_op.sv
// logic_op
//   Purely combinational WIDTH-bit bitwise operator.
//   Ports:
//     op      in  OP_W   operation select (op_e encoding)
//     op_a    in  WIDTH  operand A (already muxed: a or accumulator)
//     op_b    in  WIDTH  operand B
//     result  out WIDTH  op(op_a, op_b)
module logic_op
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case can leave it unassigned (no latch).
        result = '0;
        case (op_e'(op))
            OP_AND:  result = op_a & op_b;
            OP_OR:   result = op_a | op_b;
            OP_XOR:  result = op_a ^ op_b;
            OP_NAND: result = ~(op_a & op_b);
            OP_NOR:  result = ~(op_a | op_b);
            OP_XNOR: result = ~(op_a ^ op_b);
            OP_NOT:  result = ~op_a;
            OP_PASS: result = op_b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_n.sv
// logic_unit_n
//   Registered WIDTH-bit eight-operation logic unit with valid/ready
//   handshakes, accumulator chaining, zero/parity flags and a wrapping
//   accepted-transaction counter.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     in_valid / in_ready  input handshake (accept = in_valid && in_ready)
//     op, a, b             operation select and operands
//     acc_mode             1: accumulator replaces operand A
//     acc_clr              synchronous accumulator clear
//     out_valid/out_ready  output handshake
//     y, zero, parity      registered result and its flags
//     acc                  accumulator value
//     op_count             accepted-transaction count (wraps)
module logic_unit_n
    import logic_unit_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               acc_mode,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   y,
    output logic               zero,
    output logic               parity,
    output logic [WIDTH-1:0]   acc,
    output logic [COUNT_W-1:0] op_count
);

    out_state_e         state_q, state_d;
    logic               accept;
    logic [WIDTH-1:0]   operand_a;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   y_q;
    logic               zero_q, parity_q;
    logic [WIDTH-1:0]   acc_q;
    logic [COUNT_W-1:0] count_q;

    // Depends only on the output register state and out_ready, so there is
    // no combinational path from in_valid back to in_ready.
    assign in_ready = (state_q == ST_EMPTY) || out_ready;
    assign accept   = in_valid && in_ready;

    // A clear arriving with an accumulate op makes that op see a zero
    // accumulator, so the clear and the chained op can share one cycle.
    assign operand_a = acc_mode ? (acc_clr ? '0 : acc_q) : a;

    logic_op #(.WIDTH(WIDTH)) u_op (
        .op     (op),
        .op_a   (operand_a),
        .op_b   (b),
        .result (result)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL: begin
                if (accept)         state_d = ST_FULL;
                else if (out_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            y_q      <= '0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            if (accept) begin
                y_q      <= result;
                zero_q   <= (result == '0);
                parity_q <= ^result;
                acc_q    <= result;     // accept write wins over acc_clr
                count_q  <= count_q + COUNT_W'(1);
            end else if (acc_clr) begin
                acc_q <= '0;
            end
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign y         = y_q;
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign acc       = acc_q;
    assign op_count  = count_q;

endmodule

// File: tb/tb_logic_unit_n.sv
module tb_logic_unit_n;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [2:0]    op;
    logic [W-1:0]  a, b;
    logic          acc_mode, acc_clr;
    logic          out_valid, out_ready;
    logic [W-1:0]  y, acc;
    logic          zero, parity;
    logic [CW-1:0] op_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state, derived from the behavioural rules of the unit.
    logic [W-1:0] m_y, m_acc;
    logic         m_zero, m_par, m_valid;
    int           m_cnt;

    logic [7:0] tt_exp [8] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, 8'hCC};

    logic_unit_n #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .acc_mode  (acc_mode),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .parity    (parity),
        .acc       (acc),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input int code, input logic [W-1:0] x, input logic [W-1:0] z);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            int s;
            s = int'(x[i]) + int'(z[i]);   // number of ones in this bit pair
            case (code)
                0: r[i] = (s == 2);
                1: r[i] = (s >= 1);
                2: r[i] = (s == 1);
                3: r[i] = (s != 2);
                4: r[i] = (s == 0);
                5: r[i] = (s != 1);
                6: r[i] = (x[i] == 1'b0);
                default: r[i] = z[i];
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        m_y = '0; m_acc = '0; m_zero = 0; m_par = 0; m_valid = 0; m_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".y"},         32'(y),         32'(m_y));
        check({tag, ".acc"},       32'(acc),       32'(m_acc));
        check({tag, ".op_count"},  32'(op_count),  32'(m_cnt));
        if (m_valid) begin
            check({tag, ".zero"},   32'(zero),   32'(m_zero));
            check({tag, ".parity"}, 32'(parity), 32'(m_par));
        end
    endtask

    // One clock: entered at posedge+1, drives inputs, checks in_ready before
    // the edge, advances the model at the edge and checks the outputs after.
    task automatic cycle(input string tag, input logic iv, input logic [2:0] o,
                         input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic am, input logic ac, input logic ordy);
        logic         acc_ok;
        logic [W-1:0] opa, res;
        in_valid = iv; op = o; a = av; b = bv;
        acc_mode = am; acc_clr = ac; out_ready = ordy;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || ordy));
        acc_ok = iv && (!m_valid || ordy);
        opa = am ? (ac ? '0 : m_acc) : av;
        res = ref_op(int'(o), opa, bv);
        @(posedge clk);
        #1;
        if (acc_ok) begin
            m_y = res; m_zero = (res == 0); m_par = ^res; m_valid = 1;
            m_acc = res; m_cnt = (m_cnt + 1) % (1 << CW);
        end else begin
            if (ac) m_acc = '0;
            if (m_valid && ordy) m_valid = 0;
        end
        check_outputs(tag);
    endtask

    task automatic idle();
        in_valid = 0; op = '0; a = '0; b = '0;
        acc_mode = 0; acc_clr = 0; out_ready = 1;
    endtask

    // Asynchronous reset away from the clock edge, checked before any edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        check_outputs(tag);
        check({tag, ".zero"},   32'(zero),   32'd0);
        check({tag, ".parity"}, 32'(parity), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        model_reset();
        #12;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check_outputs("rst");
        check("rst.zero", 32'(zero), 32'd0);
        check("rst.parity", 32'(parity), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;

        // 1. Truth table, back-to-back.
        for (int i = 0; i < 8; i++) begin
            cycle("tt", 1, 3'(i), 8'hF0, 8'hCC, 0, 0, 1);
            check("tt.lit", 32'(y), 32'(tt_exp[i]));
        end

        // 2. Backpressure.
        cycle("bp.acc", 1, 3'd0, 8'hF0, 8'hCC, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle("bp.hold", 1, 3'd1, 8'h55, 8'hAA, 0, 0, 0);
            check("bp.hold.y", 32'(y), 32'hC0);
            check("bp.hold.in_ready", 32'(in_ready), 32'd0);
        end
        cycle("bp.drain", 0, 3'd0, 8'h00, 8'h00, 0, 0, 1);
        check("bp.drain.out_valid", 32'(out_valid), 32'd0);
        check("bp.drain.y", 32'(y), 32'hC0);

        // 3. Accumulate chain, then clear coincident with an accumulate op.
        cycle("acc.clr", 0, 3'd0, 8'h00, 8'h00, 0, 1, 1);
        check("acc.clr.lit", 32'(acc), 32'd0);
        cycle("acc.x1", 1, 3'd2, 8'hFF, 8'h01, 1, 0, 1);
        check("acc.x1.lit", 32'(y), 32'h01);
        cycle("acc.x2", 1, 3'd2, 8'hFF, 8'h02, 1, 0, 1);
        check("acc.x2.lit", 32'(y), 32'h03);
        cycle("acc.x4", 1, 3'd2, 8'hFF, 8'h04, 1, 0, 1);
        check("acc.x4.lit", 32'(acc), 32'h07);
        cycle("acc.clr_or", 1, 3'd1, 8'hFF, 8'h10, 1, 1, 1);
        check("acc.clr_or.lit", 32'(y), 32'h10);
        check("acc.clr_or.acc", 32'(acc), 32'h10);

        // 4. Flags.
        cycle("flag.z", 1, 3'd0, 8'h0F, 8'hF0, 0, 0, 1);
        check("flag.z.zero", 32'(zero), 32'd1);
        check("flag.z.parity", 32'(parity), 32'd0);
        cycle("flag.p1", 1, 3'd2, 8'h01, 8'h00, 0, 0, 1);
        check("flag.p1.zero", 32'(zero), 32'd0);
        check("flag.p1.parity", 32'(parity), 32'd1);
        cycle("flag.p0", 1, 3'd2, 8'h03, 8'h00, 0, 0, 1);
        check("flag.p0.parity", 32'(parity), 32'd0);

        // 5. Counter wrap (COUNT_W=4): 17 accepts -> 1; stalled offer ignored.
        async_reset("wrap.rst");
        for (int i = 0; i < 17; i++)
            cycle("wrap", 1, 3'd7, 8'h00, 8'(i), 0, 0, 1);
        check("wrap.lit", 32'(op_count), 32'd1);
        cycle("wrap.stall", 1, 3'd7, 8'h00, 8'h99, 0, 0, 0);
        check("wrap.stall.lit", 32'(op_count), 32'd1);

        // 6. Reset mid-stream with out_valid=1, acc=07, op_count=5.
        async_reset("mid.rst0");
        cycle("mid.p", 1, 3'd7, 8'h00, 8'h00, 0, 0, 1);
        cycle("mid.p", 1, 3'd7, 8'h00, 8'h00, 0, 0, 1);
        cycle("mid.x", 1, 3'd2, 8'h00, 8'h01, 1, 0, 1);
        cycle("mid.x", 1, 3'd2, 8'h00, 8'h02, 1, 0, 1);
        cycle("mid.x", 1, 3'd2, 8'h00, 8'h04, 1, 0, 1);
        check("mid.pre.acc", 32'(acc), 32'h07);
        check("mid.pre.cnt", 32'(op_count), 32'd5);
        async_reset("mid.rst");
        check("mid.rst.out_valid", 32'(out_valid), 32'd0);
        check("mid.rst.acc", 32'(acc), 32'd0);
        cycle("mid.first", 1, 3'd1, 8'h12, 8'h34, 0, 0, 1);
        check("mid.first.cnt", 32'(op_count), 32'd1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            cycle("rnd",
                  logic'($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)),
                  8'($urandom), 8'($urandom),
                  logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 7) == 0),
                  logic'($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
